result_writeback: RTL and testbench

Downstream stage of the matrix-vector multiply unit. On each rising edge of the multiplier's `done`, captures the DEPTH result elements and their sum, then writes them as 32-bit words to memory over an Avalon-MM write master. It is the write-back path that follows the Avalon load master and matmul core.

---
 rtl/result_writeback.sv | 121 ++++++++++++
 tb/tb_result_writeback.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_writeback.sv
// Result write-back: on a rising edge of done, snapshots DEPTH results plus their sum
// and streams them as 32-bit words through an Avalon-MM write master.
module result_writeback_lane #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       q <= '0;
        else if (load) q <= d;
    end
endmodule

module result_writeback #(
    parameter int          DEPTH        = 8,
    parameter int          RESULT_WIDTH = 24,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                done,
    input  logic [DEPTH-1:0][RESULT_WIDTH-1:0]  c_vector,
    input  logic [RESULT_WIDTH-1:0]             sum,
    output logic [31:0]                         avm_address,
    output logic                                avm_write,
    output logic [31:0]                         avm_writedata,
    output logic [3:0]                          avm_byteenable,
    input  logic                                avm_waitrequest,
    output logic                                wb_busy,
    output logic                                wb_done,
    output logic                                overrun
);
    localparam int IW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, WRITE, FINISH} state_t;

    state_t                             state, state_n;
    logic                               done_q;
    logic                               trig;
    logic                               capture;
    logic [IW-1:0]                      idx, idx_n;
    logic [31:0]                        addr, addr_n;
    logic                               ovr;
    logic [DEPTH:0][RESULT_WIDTH-1:0]   din;
    logic [DEPTH:0][RESULT_WIDTH-1:0]   cap;

    assign trig    = done & ~done_q;
    assign capture = trig && (state == IDLE);

    // Word DEPTH of the snapshot is the sum, so one index walks the whole burst.
    for (genvar g = 0; g < DEPTH; g++) begin : g_din
        assign din[g] = c_vector[g];
    end
    assign din[DEPTH] = sum;

    for (genvar g = 0; g <= DEPTH; g++) begin : g_lane
        result_writeback_lane #(.W(RESULT_WIDTH)) u_lane (
            .clk  (clk),
            .rst  (rst),
            .load (capture),
            .d    (din[g]),
            .q    (cap[g])
        );
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        addr_n  = addr;
        case (state)
            IDLE: begin
                if (trig) begin
                    state_n = WRITE;
                    idx_n   = '0;
                    addr_n  = BASE_ADDR;
                end
            end
            WRITE: begin
                if (!avm_waitrequest) begin
                    if (idx == IW'(DEPTH)) begin
                        state_n = FINISH;
                    end else begin
                        idx_n  = idx + 1'b1;
                        addr_n = addr + 32'd4;
                    end
                end
            end
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            done_q <= 1'b1;
            idx    <= '0;
            addr   <= '0;
            ovr    <= 1'b0;
        end else begin
            state  <= state_n;
            done_q <= done;
            idx    <= idx_n;
            addr   <= addr_n;
            if (trig && state != IDLE) ovr <= 1'b1;
        end
    end

    // All outputs derive from registers only; waitrequest never reaches them combinationally.
    assign avm_write      = (state == WRITE);
    assign avm_byteenable = avm_write ? 4'hF : 4'h0;
    assign avm_address    = addr;
    assign avm_writedata  = avm_write ? 32'(cap[idx]) : 32'h0;
    assign wb_busy        = (state != IDLE);
    assign wb_done        = (state == FINISH);
    assign overrun        = ovr;
endmodule

// File: tb/tb_result_writeback.sv
// Scoreboard bench for result_writeback: stimulus queues expected writes, start and
// finish cycles; a negedge monitor compares whatever the DUT presents.
module tb_result_writeback;
    logic             clk = 1'b0;
    logic             rst;
    logic             done;
    logic [7:0][23:0] cvec;
    logic [23:0]      sm;
    logic [31:0]      avm_address;
    logic             avm_write;
    logic [31:0]      avm_writedata;
    logic [3:0]       avm_byteenable;
    logic             avm_waitrequest;
    logic             wb_busy;
    logic             wb_done;
    logic             overrun;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int plan [0:8];

    logic [63:0] exp_wr[$];
    int          exp_start[$];
    int          exp_fin[$];

    result_writeback dut (
        .clk            (clk),
        .rst            (rst),
        .done           (done),
        .c_vector       (cvec),
        .sum            (sm),
        .avm_address    (avm_address),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_byteenable (avm_byteenable),
        .avm_waitrequest(avm_waitrequest),
        .wb_busy        (wb_busy),
        .wb_done        (wb_done),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s got %h want %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Slave model: stalls each newly presented word for plan[word] cycles.
    int          stall_left = 0;
    logic        last_w = 1'b0;
    logic [31:0] last_a = '0;
    always @(posedge clk) begin
        #1;
        if (avm_write) begin
            if (!last_w || avm_address != last_a)
                stall_left = ((avm_address >> 2) < 9) ? plan[avm_address >> 2] : 0;
            avm_waitrequest = (stall_left > 0);
            if (stall_left > 0) stall_left--;
        end else begin
            avm_waitrequest = 1'b0;
            stall_left      = 0;
        end
        last_w = avm_write;
        last_a = avm_address;
    end

    // Monitor
    logic        prev_write = 1'b0, prev_stall = 1'b0, prev_done = 1'b0;
    logic [31:0] prev_addr = '0, prev_data = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_write = 1'b0;
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            chk(avm_byteenable === (avm_write ? 4'hF : 4'h0), "byteenable", 32'(avm_byteenable),
                avm_write ? 32'hF : 32'h0);
            if (avm_write && !prev_write) begin
                if (exp_start.size() == 0) chk(1'b0, "start_unexpected", 32'(cyc), 32'h0);
                else begin
                    int s;
                    s = exp_start.pop_front();
                    chk(cyc == s, "start_cycle", 32'(cyc), 32'(s));
                end
            end
            if (avm_write && prev_stall) begin
                chk(avm_address === prev_addr, "stall_addr_hold", avm_address, prev_addr);
                chk(avm_writedata === prev_data, "stall_data_hold", avm_writedata, prev_data);
            end
            if (avm_write && !avm_waitrequest) begin
                if (exp_wr.size() == 0) chk(1'b0, "write_unexpected", avm_address, avm_writedata);
                else begin
                    logic [63:0] e;
                    e = exp_wr.pop_front();
                    chk(avm_address === e[63:32], "write_addr", avm_address, e[63:32]);
                    chk(avm_writedata === e[31:0], "write_data", avm_writedata, e[31:0]);
                end
            end
            if (wb_done) begin
                chk(!prev_done, "wb_done_single", 32'(prev_done), 32'h0);
                if (!prev_done) begin
                    if (exp_fin.size() == 0) chk(1'b0, "wb_done_unexpected", 32'(cyc), 32'h0);
                    else begin
                        int f;
                        f = exp_fin.pop_front();
                        chk(cyc == f, "wb_done_cycle", 32'(cyc), 32'(f));
                    end
                end
            end
            prev_write = avm_write;
            prev_stall = avm_write && avm_waitrequest;
            prev_done  = wb_done;
            prev_addr  = avm_address;
            prev_data  = avm_writedata;
        end
    end

    // Raise done; the trigger edge N is the next posedge. Queue nw words and, if fin,
    // the wb_done cycle (N+10 plus stalls, observed when cyc == N+9+extra).
    task automatic arm(input int nw, input bit fin, input int extra);
        int n;
        @(posedge clk); #1;
        done = 1'b1;
        n = cyc + 1;
        for (int i = 0; i < nw; i++)
            exp_wr.push_back({32'(4 * i), (i < 8) ? 32'(cvec[i]) : 32'(sm)});
        exp_start.push_back(n);
        if (fin) exp_fin.push_back(n + 9 + extra);
    endtask

    task automatic drop_done();
        @(posedge clk); #1;
        done = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wb_done && n < 200);
        if (!wb_done) chk(1'b0, "wait_wb_done_timeout", 32'(n), 32'h0);
    endtask

    task automatic wait_addr(input logic [31:0] a);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(avm_write && avm_address == a) && n < 200);
        if (!(avm_write && avm_address == a)) chk(1'b0, "wait_addr_timeout", avm_address, a);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 9; i++) plan[i] = 0;
        rst = 1'b1;
        done = 1'b0;
        avm_waitrequest = 1'b0;
        for (int i = 0; i < 8; i++) cvec[i] = 24'(i + 1);
        sm = 24'd36;
        idle(3);
        chk(avm_write === 1'b0, "rst_write", 32'(avm_write), 32'h0);
        chk(avm_address === 32'h0, "rst_addr", avm_address, 32'h0);
        chk(avm_writedata === 32'h0, "rst_data", avm_writedata, 32'h0);
        chk(avm_byteenable === 4'h0, "rst_be", 32'(avm_byteenable), 32'h0);
        chk(wb_busy === 1'b0, "rst_busy", 32'(wb_busy), 32'h0);
        chk(wb_done === 1'b0, "rst_wb_done", 32'(wb_done), 32'h0);
        chk(overrun === 1'b0, "rst_overrun", 32'(overrun), 32'h0);
        rst = 1'b0;
        idle(2);

        // Basic write-back
        arm(9, 1'b1, 0);
        drop_done();
        #1 chk(wb_busy === 1'b1, "basic_busy", 32'(wb_busy), 32'h1);
        wait_done();
        idle(2);
        chk(overrun === 1'b0, "basic_overrun", 32'(overrun), 32'h0);
        chk(wb_busy === 1'b0, "basic_idle", 32'(wb_busy), 32'h0);

        // Stall handling: 3 cycles on word 2, 1 on the sum word
        plan[2] = 3;
        plan[8] = 1;
        arm(9, 1'b1, 4);
        drop_done();
        wait_done();
        plan[2] = 0;
        plan[8] = 0;
        idle(2);

        // Capture isolation, then full-width words
        for (int i = 0; i < 8; i++) cvec[i] = 24'h100 * 24'(i + 1) + 24'h5A;
        sm = 24'hABCDEF;
        arm(9, 1'b1, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) cvec[i] = 24'hFFFFFF;
        sm = 24'hFFFFFF;
        done = 1'b0;
        wait_done();
        idle(2);
        arm(9, 1'b1, 0);
        drop_done();
        wait_done();
        idle(2);

        // Overrun: retrigger while word 4 is stalled
        for (int i = 0; i < 8; i++) cvec[i] = 24'(i + 1);
        sm = 24'd36;
        plan[4] = 4;
        arm(9, 1'b1, 4);
        drop_done();
        wait_addr(32'h10);
        @(posedge clk); #1;
        done = 1'b1;
        wait_done();
        plan[4] = 0;
        idle(6);
        chk(overrun === 1'b1, "overrun_set", 32'(overrun), 32'h1);
        chk(wb_busy === 1'b0, "overrun_no_second", 32'(wb_busy), 32'h0);
        idle(4);
        chk(overrun === 1'b1, "overrun_sticky", 32'(overrun), 32'h1);

        // Reset mid-burst with done held high
        drop_done();
        plan[5] = 100;
        arm(5, 1'b0, 0);
        wait_addr(32'h14);
        rst = 1'b1;
        #1;
        chk(avm_write === 1'b0, "midrst_write", 32'(avm_write), 32'h0);
        chk(avm_byteenable === 4'h0, "midrst_be", 32'(avm_byteenable), 32'h0);
        chk(wb_busy === 1'b0, "midrst_busy", 32'(wb_busy), 32'h0);
        chk(overrun === 1'b0, "midrst_overrun", 32'(overrun), 32'h0);
        idle(3);
        rst = 1'b0;
        plan[5] = 0;
        idle(8);
        chk(wb_busy === 1'b0, "postrst_no_burst", 32'(wb_busy), 32'h0);
        drop_done();
        arm(9, 1'b1, 0);
        drop_done();
        wait_done();

        // Back-to-back: done rises in the cycle after wb_done
        arm(9, 1'b1, 0);
        drop_done();
        wait_done();
        idle(3);
        chk(overrun === 1'b0, "b2b_overrun", 32'(overrun), 32'h0);

        idle(5);
        chk(exp_wr.size() == 0, "writes_outstanding", 32'(exp_wr.size()), 32'h0);
        chk(exp_start.size() == 0, "starts_outstanding", 32'(exp_start.size()), 32'h0);
        chk(exp_fin.size() == 0, "wb_done_outstanding", 32'(exp_fin.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got %0d want <200000", cyc);
        $fatal(1);
    end
endmodule
